// File: rtl/sdram_cmd_arbiter.sv
// N-channel command arbiter feeding SDRAM_16bit: urgent video channel 0 with its own burst counter,
// round-robin or fixed priority among the rest, starvation guard, ack-edge completion and done pulses.
module sdram_cmd_arbiter #(
    parameter int          NCH       = 4,
    parameter int          ADRW      = 18,
    parameter int          VID_WORDS = 3072,
    parameter int unsigned VID_BASE  = 'h37FC0,
    parameter int          STARVE    = 15,
    parameter int          RR_EN     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NCH-1:0]                req,
    input  logic [2*NCH-1:0]              cmd,
    input  logic [ADRW*NCH-1:0]           addr,
    input  logic                          frame_sync,
    output logic [1:0]                    sys_cmd,
    output logic [ADRW-1:0]               sys_addr,
    input  logic [1:0]                    sys_cmd_ack,
    output logic [NCH-1:0]                grant,
    output logic [NCH-1:0]                done,
    output logic [2:0]                    data_owner,
    output logic [$clog2(VID_WORDS)-1:0]  vid_adr,
    output logic                          busy,
    output logic                          err
);
    localparam int VAW = $clog2(VID_WORDS);
    localparam int SW  = $clog2(STARVE + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t          state;
    logic            ack_prev;
    logic            ack_edge;
    logic [SW-1:0]   scnt;
    logic [2:0]      rr;
    logic [2:0]      owner;
    logic [2:0]      win;
    logic [NCH-1:0]  win_oh;
    logic [1:0]      wcmd;
    logic [ADRW-1:0] waddr;
    logic [ADRW-1:0] vid_sys_addr;
    logic            others;
    logic            found;

    assign ack_edge     = ack_prev & (sys_cmd_ack != 2'b00);
    assign others       = |req[NCH-1:1];
    assign vid_sys_addr = ADRW'(VID_BASE) + ADRW'(vid_adr);

    // With RR_EN the first pass covers the pointer..top range and the second pass
    // supplies the wrap-around; without it only the second pass (lowest index) applies.
    always_comb begin
        win    = 3'd0;
        found  = 1'b0;
        wcmd   = 2'b00;
        waddr  = '0;
        win_oh = '0;
        if (RR_EN != 0) begin
            for (int i = 1; i < NCH; i++) begin
                if (!found && req[i] && i >= int'(rr)) begin
                    found = 1'b1;
                    win   = 3'(i);
                end
            end
        end
        for (int i = 1; i < NCH; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                win   = 3'(i);
            end
        end
        if (req[0] && (!others || int'(scnt) < STARVE))
            win = 3'd0;
        for (int i = 0; i < NCH; i++) begin
            if (win == 3'(i)) begin
                wcmd      = cmd[2*i +: 2];
                waddr     = addr[ADRW*i +: ADRW];
                win_oh[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ack_prev   <= 1'b0;
            scnt       <= '0;
            rr         <= 3'd1;
            owner      <= 3'd0;
            sys_cmd    <= 2'b00;
            sys_addr   <= '0;
            grant      <= '0;
            done       <= '0;
            data_owner <= 3'd0;
            vid_adr    <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            ack_prev <= (sys_cmd_ack == 2'b00);
            done     <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        sys_cmd  <= wcmd;
                        sys_addr <= (win == 3'd0) ? vid_sys_addr : waddr;
                        grant    <= win_oh;
                        busy     <= 1'b1;
                        owner    <= win;
                        state    <= ISSUE;
                        if (win == 3'd0) begin
                            if (!others)
                                scnt <= '0;
                            else if (int'(scnt) < STARVE)
                                scnt <= scnt + SW'(1);
                        end else begin
                            scnt <= '0;
                            rr   <= (int'(win) == NCH - 1) ? 3'd1 : win + 3'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (ack_edge) begin
                        sys_cmd    <= 2'b00;
                        busy       <= 1'b0;
                        grant      <= '0;
                        data_owner <= owner;
                        state      <= GAP;
                        for (int i = 0; i < NCH; i++)
                            if (owner == 3'(i)) done[i] <= 1'b1;
                        if (sys_cmd_ack != sys_cmd)
                            err <= 1'b1;
                        if (owner == 3'd0)
                            vid_adr <= (vid_adr == VAW'(VID_WORDS - 1)) ? '0 : vid_adr + VAW'(1);
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
            // A frame restart overrides any increment from a ch0 completion in the same cycle.
            if (frame_sync)
                vid_adr <= '0;
        end
    end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter: a round-robin and a fixed-priority instance share stimulus.
module tb_sdram_cmd_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [7:0]  cmd = 8'b11_01_11_10;
    logic [71:0] addr = {18'h00300, 18'h00200, 18'h00100, 18'h3FFFF};
    logic        frame_sync = 1'b0;
    logic [1:0]  sys_cmd_ack = 2'b00;

    logic [1:0]  sys_cmd, sys_cmd2;
    logic [17:0] sys_addr, sys_addr2;
    logic [3:0]  grant, grant2, done, done2;
    logic [2:0]  data_owner, data_owner2;
    logic [11:0] vid_adr, vid_adr2;
    logic        busy, busy2, err, err2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdram_cmd_arbiter #(.NCH(4), .ADRW(18), .VID_WORDS(3072), .VID_BASE('h37FC0),
                        .STARVE(15), .RR_EN(1)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd(cmd), .addr(addr), .frame_sync(frame_sync),
        .sys_cmd(sys_cmd), .sys_addr(sys_addr), .sys_cmd_ack(sys_cmd_ack), .grant(grant),
        .done(done), .data_owner(data_owner), .vid_adr(vid_adr), .busy(busy), .err(err));

    sdram_cmd_arbiter #(.NCH(4), .ADRW(18), .VID_WORDS(3072), .VID_BASE('h37FC0),
                        .STARVE(15), .RR_EN(0)) dut2 (
        .clk(clk), .rst(rst), .req(req), .cmd(cmd), .addr(addr), .frame_sync(frame_sync),
        .sys_cmd(sys_cmd2), .sys_addr(sys_addr2), .sys_cmd_ack(sys_cmd_ack), .grant(grant2),
        .done(done2), .data_owner(data_owner2), .vid_adr(vid_adr2), .busy(busy2), .err(err2));

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  g1;
        logic [3:0]  g2;
        logic [1:0]  scmd;
        logic [17:0] saddr;
        logic [11:0] vid;
        int          dly;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] oh2idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++)
            if (oh[i]) return 3'(i);
        return 3'd0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req = '0; frame_sync = 1'b0; sys_cmd_ack = 2'b00;
        #1;
        chk("reset_outputs", {sys_cmd, sys_addr, grant, done, data_owner, vid_adr, busy, err}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One command: raise req, wait for busy, ack after dly cycles (code 0 echoes sys_cmd).
    task automatic txn(input logic [3:0] r, input int dly, input logic [1:0] code, input bit fs,
                       input bit hold, input bit quiet, input logic [3:0] eg1, input logic [3:0] eg2,
                       output logic [1:0] sc, output logic [17:0] sa, output int lat);
        bit got = 1'b0;
        @(negedge clk);
        req = r;
        lat = 0;
        sc = 2'b00;
        sa = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (busy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout actual=0 required=1");
            req = '0;
            return;
        end
        sc = sys_cmd;
        sa = sys_addr;
        if (!quiet) begin
            chk("grant_rr", grant, eg1);
            chk("grant_fixed", grant2, eg2);
        end
        for (int i = 0; i < dly - 1; i++) begin
            @(posedge clk); #1;
        end
        sys_cmd_ack = (code == 2'b00) ? sys_cmd : code;
        frame_sync = fs;
        @(posedge clk); #1;
        sys_cmd_ack = 2'b00;
        frame_sync = 1'b0;
        if (!hold) req = '0;
        if (!quiet) begin
            chk("done_pulse", done, eg1);
            chk("data_owner", data_owner, oh2idx(eg1));
            chk("idle_after_ack", {busy, sys_cmd, grant}, 7'd0);
        end
        @(posedge clk); #1;
        if (!quiet) chk("done_one_cycle", done, 4'd0);
    endtask

    logic [1:0]  sc;
    logic [17:0] sa;
    int          lat;
    logic [3:0]  exp3 [4];
    logic [3:0]  eg;

    initial begin
        tbl[0] = '{4'b0001, 4'b0001, 4'b0001, 2'b10, 18'h37FC0, 12'd1, 3};
        tbl[1] = '{4'b0100, 4'b0100, 4'b0100, 2'b01, 18'h00200, 12'd1, 1};
        tbl[2] = '{4'b1010, 4'b1000, 4'b0010, 2'b11, 18'h00300, 12'd1, 2};
        tbl[3] = '{4'b0001, 4'b0001, 4'b0001, 2'b10, 18'h37FC1, 12'd2, 1};
        tbl[4] = '{4'b1111, 4'b0001, 4'b0001, 2'b10, 18'h37FC2, 12'd3, 2};
        tbl[5] = '{4'b0110, 4'b0010, 4'b0010, 2'b11, 18'h00100, 12'd3, 1};
        tbl[6] = '{4'b1100, 4'b0100, 4'b0100, 2'b01, 18'h00200, 12'd3, 3};
        exp3 = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};

        #2;
        do_reset();

        for (int v = 0; v < 7; v++) begin
            txn(tbl[v].req, tbl[v].dly, 2'b00, 1'b0, 1'b0, 1'b0, tbl[v].g1, tbl[v].g2, sc, sa, lat);
            chk("latency", lat, 1);
            chk("sys_cmd", sc, tbl[v].scmd);
            chk("sys_addr", sa, tbl[v].saddr);
            chk("vid_adr", vid_adr, tbl[v].vid);
        end
        chk("err_clean", err, 1'b0);

        // Round-robin rotation vs fixed priority with 1110 held.
        do_reset();
        for (int n = 0; n < 4; n++)
            txn(4'b1110, 1, 2'b00, 1'b0, 1'b1, 1'b0, exp3[n], 4'b0010, sc, sa, lat);

        // Starvation guard: 15 ch0 grants, one ch1, then ch0.
        do_reset();
        for (int n = 0; n < 17; n++) begin
            eg = (n == 15) ? 4'b0010 : 4'b0001;
            txn(4'b0011, 1, 2'b00, 1'b0, 1'b1, 1'b0, eg, eg, sc, sa, lat);
        end

        // Video counter wrap at VID_WORDS-1 and frame_sync in the ack cycle.
        do_reset();
        for (int n = 0; n < 3071; n++)
            txn(4'b0001, 1, 2'b00, 1'b0, 1'b1, 1'b1, 4'b0001, 4'b0001, sc, sa, lat);
        chk("vid_at_last", vid_adr, 12'd3071);
        txn(4'b0001, 1, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0001, sc, sa, lat);
        chk("addr_last_burst", sa, 18'h38BBF);
        chk("vid_wrapped", vid_adr, 12'd0);
        txn(4'b0001, 1, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0001, sc, sa, lat);
        chk("addr_after_wrap", sa, 18'h37FC0);
        chk("vid_after_wrap", vid_adr, 12'd1);
        txn(4'b0001, 2, 2'b00, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, sc, sa, lat);
        chk("addr_sync_cmd", sa, 18'h37FC1);
        chk("vid_sync_wins", vid_adr, 12'd0);

        // Ack code mismatch, sticky err, then reset in the middle of ISSUE.
        do_reset();
        txn(4'b1000, 1, 2'b01, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, sc, sa, lat);
        chk("mismatch_cmd", sc, 2'b11);
        chk("err_set", err, 1'b1);
        txn(4'b0100, 2, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0100, sc, sa, lat);
        chk("err_sticky", err, 1'b1);
        @(negedge clk);
        req = 4'b0010;
        @(posedge clk); #1;
        chk("busy_before_rst", {busy, grant}, 5'b1_0010);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset", {sys_cmd, sys_addr, grant, done, data_owner, vid_adr, busy, err}, 64'd0);
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
